piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and drives it out one bit per enabled clock edge.
- Transmit-side counterpart to the team's serial-capture chain, which is built from enabled D flip-flops sampling one bit per enabled edge.
- `enable` is the bit-rate strobe shared with the receiving end.
- Supports back-to-back words with no idle bit between them.

---
 rtl/seq_pkg.sv | 14 +
 rtl/bit_counter.sv | 26 ++
 rtl/piso_serializer.sv | 105 ++++++++++
 tb/tb_piso_serializer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial transmit/capture chain: FSM states and counter sizing.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width for a WIDTH-bit word; the counter holds bits remaining after the current one.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with decrement enable and a combinational zero flag.
module bit_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_zero_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign is_zero_c = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word intake, one bit out per enabled edge.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_n;
    logic [WIDTH-1:0] shreg_q, shreg_n;
    logic             ser_valid_n, frame_start_n, done_n;
    logic             cnt_load, cnt_dec, cnt_zero, accept;
    logic [CW-1:0]    cnt;

    bit_counter #(.W(CW)) u_cnt (
        .clk        (Clk),
        .rst_n      (reset),
        .load       (cnt_load),
        .load_value (CW'(WIDTH - 1)),
        .dec        (cnt_dec),
        .count      (cnt),
        .is_zero_c  (cnt_zero)
    );

    // Ready in IDLE, or on the edge that retires the last bit so words run back-to-back.
    assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero && enable);
    assign accept   = in_valid && in_ready;

    // The output bit is taken straight from the shift register's output-end flop.
    assign ser_out  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_n;
            shreg_q     <= shreg_n;
            ser_valid   <= ser_valid_n;
            frame_start <= frame_start_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        shreg_n       = shreg_q;
        ser_valid_n   = ser_valid;
        frame_start_n = frame_start;
        done_n        = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;

        case (state_q)
            IDLE: begin
                shreg_n       = '0;
                ser_valid_n   = 1'b0;
                frame_start_n = 1'b0;
            end
            SHIFT: begin
                if (enable) begin
                    if (!cnt_zero) begin
                        shreg_n       = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                                  : {1'b0, shreg_q[WIDTH-1:1]};
                        cnt_dec       = 1'b1;
                        frame_start_n = 1'b0;
                    end else begin
                        done_n        = 1'b1;
                        state_n       = IDLE;
                        shreg_n       = '0;
                        ser_valid_n   = 1'b0;
                        frame_start_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A load overrides the idle/retire defaults above.
        if (accept) begin
            state_n       = SHIFT;
            shreg_n       = in_data;
            cnt_load      = 1'b1;
            ser_valid_n   = 1'b1;
            frame_start_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench: MSB-first and LSB-first instances driven with identical stimulus.
module tb_piso_serializer;

    localparam int unsigned WIDTH = 8;

    logic             Clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;

    logic m_ready, m_ser, m_sv, m_fs, m_done;
    logic l_ready, l_ser, l_sv, l_fs, l_done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .Clk(Clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .ser_out(m_ser), .ser_valid(m_sv), .frame_start(m_fs), .done(m_done)
    );

    piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .Clk(Clk), .reset(reset), .enable(enable), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .ser_out(l_ser), .ser_valid(l_sv), .frame_start(l_fs), .done(l_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Step one clock and settle just past the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Check both instances: serial bits, and shared valid/frame/done/ready flags.
    task automatic check_outs(input string tag, input logic exp_m, input logic exp_l,
                              input logic sv, input logic fs, input logic dn);
        check({tag, " m_ser"}, 32'(m_ser), 32'(exp_m));
        check({tag, " l_ser"}, 32'(l_ser), 32'(exp_l));
        check({tag, " m_sv"}, 32'(m_sv), 32'(sv));
        check({tag, " l_sv"}, 32'(l_sv), 32'(sv));
        check({tag, " m_fs"}, 32'(m_fs), 32'(fs));
        check({tag, " l_fs"}, 32'(l_fs), 32'(fs));
        check({tag, " m_done"}, 32'(m_done), 32'(dn));
        check({tag, " l_done"}, 32'(l_done), 32'(dn));
    endtask

    logic [7:0] seq_m;
    logic [7:0] seq_l;

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset ready", 32'(m_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Single word A5: MSB-first 1,0,1,0,0,1,0,1; LSB-first also 1,0,1,0,0,1,0,1.
        seq_m = 8'b1010_0101;
        seq_l = 8'b1010_0101;
        in_data = 8'hA5; in_valid = 1'b1;
        check("a5 ready idle", 32'(m_ready), 32'd1);
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check_outs($sformatf("a5 b%0d", i), seq_m[7-i], seq_l[7-i], 1'b1, i == 0, 1'b0);
            check($sformatf("a5 ready b%0d", i), 32'(m_ready), 32'(i == 7));
            tick();
        end
        check_outs("a5 done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("a5 after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single word 01: MSB-first 0,0,0,0,0,0,0,1; LSB-first 1,0,0,0,0,0,0,0.
        seq_m = 8'b0000_0001;
        seq_l = 8'b1000_0000;
        in_data = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_outs($sformatf("01 b%0d", i), seq_m[7-i], seq_l[7-i], 1'b1, i == 0, 1'b0);
            tick();
        end
        check_outs("01 done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Enable every 4th cycle, C3: MSB 1,1,0,0,0,0,1,1; LSB identical (palindrome).
        seq_m = 8'b1100_0011;
        seq_l = 8'b1100_0011;
        enable = 1'b0; in_data = 8'hC3; in_valid = 1'b1;
        check("c3 ready en0", 32'(m_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 4; k++) begin
                check_outs($sformatf("c3 b%0d c%0d", j, k), seq_m[7-j], seq_l[7-j], 1'b1, j == 0, 1'b0);
                enable = (k == 3);
                tick();
            end
        end
        enable = 1'b0;
        check_outs("c3 done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("c3 after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;

        // Back-to-back FF then 00 with in_valid held high.
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            check_outs($sformatf("b2b c%0d", i), i < 8, i < 8, 1'b1, (i == 0) || (i == 8), i == 8);
            if (i == 15) in_valid = 1'b0;
            tick();
        end
        check_outs("b2b done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Stall: new word offered mid-word, data changes until acceptance at the last-bit edge.
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) in_data = 8'h5A;
            if (i == 7) in_data = 8'h96;
            check($sformatf("stall ready c%0d", i), 32'(m_ready), 32'(i == 7));
            check($sformatf("stall l_ready c%0d", i), 32'(l_ready), 32'(i == 7));
            tick();
        end
        in_valid = 1'b0; in_data = 8'hFF;
        // 96 = 1001_0110: MSB-first 1,0,0,1,0,1,1,0; LSB-first 0,1,1,0,1,0,0,1.
        seq_m = 8'b1001_0110;
        seq_l = 8'b0110_1001;
        for (int i = 0; i < 8; i++) begin
            check_outs($sformatf("96 b%0d", i), seq_m[7-i], seq_l[7-i], 1'b1, i == 0, i == 0);
            tick();
        end
        check_outs("96 done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // Asynchronous reset after 3 bits of A5: clears immediately, no done afterwards.
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check_outs("pre-rst b3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("mid rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid rst ready", 32'(m_ready), 32'd1);
        check("mid rst l_ready", 32'(l_ready), 32'd1);
        tick();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_outs($sformatf("post rst c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("post rst ready c%0d", i), 32'(m_ready), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
